// File: rtl/fir_filter.sv
// 41-tap direct-form FIR filter with run-time programmable Q1.15 coefficients.
// One sample in and one registered, floor-shifted and saturated sample out per clock.
module fir_filter #(
    parameter int NTAPS = 41,
    parameter int DW    = 16,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] dout,
    input  logic                 coeff_update,
    input  logic [5:0]           coeff_sel,
    input  logic signed [CW-1:0] new_coeff
);
    localparam int PW = DW + CW;
    localparam int AW = PW + $clog2(NTAPS);
    localparam int SH = CW - 1;

    // x_q[0] holds x[1]; din itself is tap x[0]
    logic signed [DW-1:0] x_q [NTAPS-1];
    logic signed [CW-1:0] c_q [NTAPS];
    logic signed [DW-1:0] dout_q;
    logic signed [DW-1:0] dout_d;
    logic signed [DW-1:0] tap [NTAPS];
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic                 wr_en;

    // Arithmetic shift (floor) by the coefficient fraction width, then clamp to DW bits.
    function automatic logic signed [DW-1:0] asr_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        hi = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        s  = a >>> SH;
        if (s > hi) begin
            return hi[DW-1:0];
        end else if (s < lo) begin
            return lo[DW-1:0];
        end
        return s[DW-1:0];
    endfunction

    always_comb begin
        tap[0] = din;
        for (int k = 1; k < NTAPS; k++) begin
            tap[k] = x_q[k-1];
        end
    end

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int k = 0; k < NTAPS; k++) begin
            prod = PW'(tap[k]) * PW'(c_q[k]);
            acc  = acc + AW'(prod);
        end
        dout_d = asr_sat(acc);
    end

    assign wr_en = coeff_update && (32'(coeff_sel) < NTAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            for (int k = 0; k < NTAPS-1; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < NTAPS; k++) begin
                c_q[k] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            x_q[0] <= din;
            for (int k = 1; k < NTAPS-1; k++) begin
                x_q[k] <= x_q[k-1];
            end
            // the product sum above still sees the old coefficient this edge
            if (wr_en) begin
                c_q[coeff_sel] <= new_coeff;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: arithmetic reference model plus directed literal checks.
module tb_fir_filter;
    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] din;
    logic signed [15:0] dout;
    logic               coeff_update;
    logic [5:0]         coeff_sel;
    logic signed [15:0] new_coeff;

    int errors = 0;
    int checks = 0;

    // reference state: delayed samples mh[1..40] and coefficients mc[0..40]
    longint      mh [41];
    longint      mc [41];
    logic [15:0] exp_dout;
    logic        exp_vld = 1'b0;

    fir_filter dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .dout         (dout),
        .coeff_update (coeff_update),
        .coeff_sel    (coeff_sel),
        .new_coeff    (new_coeff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: dout=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic lit(input string name, input logic [15:0] req);
        chk(name, dout, req);
    endtask

    function automatic logic [15:0] model_out(input longint x0);
        longint s;
        longint q;
        s = x0 * mc[0];
        for (int k = 1; k < 41; k++) begin
            s += mh[k] * mc[k];
        end
        q = s / 32768;
        if (s < 0 && (s % 32768) != 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 41; k++) begin
                mh[k] = 0;
                mc[k] = 0;
            end
            exp_dout = 16'h0000;
        end else begin
            exp_dout = model_out(longint'(din));
            if (coeff_update && coeff_sel < 6'd41) mc[coeff_sel] = longint'(new_coeff);
            for (int k = 40; k >= 2; k--) mh[k] = mh[k-1];
            mh[1] = longint'(din);
        end
        exp_vld = 1'b1;
    end

    always @(negedge clk) begin
        if (exp_vld) chk("model", dout, exp_dout);
    end

    task automatic wr(input int sel, input logic [15:0] val);
        coeff_update = 1'b1;
        coeff_sel    = 6'(sel);
        new_coeff    = val;
        @(negedge clk);
        coeff_update = 1'b0;
    endtask

    task automatic write_all(input logic [15:0] val);
        for (int k = 0; k < 41; k++) wr(k, val);
    endtask

    initial begin
        reset        = 1'b1;
        din          = 16'h7FFF;
        coeff_update = 1'b0;
        coeff_sel    = '0;
        new_coeff    = '0;
        @(negedge clk);
        @(negedge clk);
        lit("reset_hold", 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            din = 16'($urandom);
            @(negedge clk);
            lit("zero_coeffs", 16'h0000);
        end

        // impulse through tap 3; writes to 41 and 63 must not alter it
        din = 16'h0000;
        wr(3, 16'h7FFF);
        wr(41, 16'h7FFF);
        wr(63, 16'h1234);
        repeat (45) @(negedge clk);
        din = 16'h4000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lit("impulse", (i == 3) ? 16'h3FFF : 16'h0000);
            din = 16'h0000;
        end

        din = 16'hFFFF;
        write_all(16'hFFFF);
        repeat (45) @(negedge clk);
        lit("minus1_ffff", 16'h0000);
        din = 16'h1111;
        repeat (45) @(negedge clk);
        lit("minus1_1111", 16'hFFFA);

        // coefficient write coinciding with a nonzero sample
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        din   = 16'h0000;
        wr(0, 16'h4000);
        repeat (3) @(negedge clk);
        din          = 16'h2000;
        coeff_update = 1'b1;
        coeff_sel    = 6'd0;
        new_coeff    = 16'h7FFF;
        @(negedge clk);
        lit("wr_old_c0", 16'h1000);
        coeff_update = 1'b0;
        @(negedge clk);
        lit("wr_new_c0", 16'h1FFF);

        for (int i = 0; i < 400; i++) begin
            din          = 16'($urandom);
            reset        = ($urandom_range(0, 99) == 0);
            coeff_update = ($urandom_range(0, 3) == 0);
            coeff_sel    = 6'($urandom_range(0, 63));
            new_coeff    = 16'($urandom);
            @(negedge clk);
        end
        reset        = 1'b0;
        coeff_update = 1'b0;

        din = 16'h7FFF;
        write_all(16'h7FFF);
        repeat (45) @(negedge clk);
        lit("sat_pos", 16'h7FFF);
        din = 16'h8000;
        repeat (45) @(negedge clk);
        lit("sat_neg", 16'h8000);

        reset = 1'b1;
        @(negedge clk);
        lit("mid_reset", 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lit("post_reset", 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
